hyperbus_xfer_ctrl: RTL and testbench

//  Single-word HyperBus transaction sequencer that drives the ioddr DDR pad block.

---
 rtl/hyperbus_xfer_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_hyperbus_xfer_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hyperbus_xfer_ctrl.sv
// hyperbus_xfer_ctrl: single-word HyperBus read/write sequencer.
// Walks CS# low through the command/address phase, the fixed initial
// latency and one data word, then holds CS# high for the recovery time.
// Every output is a flop whose D value is derived from the next state.
module hyperbus_xfer_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int LATENCY    = 6,
  parameter int RECOVERY   = 2,
  parameter int TIMEOUT    = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] adr_i,
  input  logic [15:0]           dat_i,
  output logic [15:0]           dat_o,
  output logic                  ack_o,
  output logic                  err_o,
  output logic                  busy_o,
  output logic                  csn_o,
  output logic                  ck_en_o,
  output logic                  ddr_oe_o,
  output logic [15:0]           ddr_dat_o,
  input  logic [15:0]           ddr_dat_i,
  output logic                  rwds_oe_o,
  output logic                  rwds_o,
  input  logic                  rwds_i
);

  typedef enum logic [2:0] {
    S_IDLE, S_CA0, S_CA1, S_CA2, S_LAT, S_DATA, S_RECOV
  } state_t;

  // One shared in-state cycle counter, wide enough for the longest dwell.
  localparam int CNT_MAX0 = (LATENCY > RECOVERY) ? LATENCY : RECOVERY;
  localparam int CNT_MAX  = (CNT_MAX0 > TIMEOUT) ? CNT_MAX0 : TIMEOUT;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] LAT_LAST   = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] RECOV_LAST = CNT_W'(RECOVERY - 1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [31:0]       adr_q, adr_d;
  logic [15:0]       wdat_q, wdat_d;
  logic              rd_hit, rd_to;
  logic [47:0]       ca;

  logic              csn_q, csn_d;
  logic              ck_en_q, ck_en_d;
  logic              ddr_oe_q, ddr_oe_d;
  logic [15:0]       ddr_dat_q, ddr_dat_d;
  logic              rwds_oe_q, rwds_oe_d;
  logic              rwds_q, rwds_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic [15:0]       dat_q, dat_d;

  // Next-state, request capture and in-state cycle counter.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    rd_hit  = 1'b0;
    rd_to   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          state_d = S_CA0;
          we_d    = we_i;
          adr_d   = 32'(adr_i);
          wdat_d  = dat_i;
        end
      end
      S_CA0: state_d = S_CA1;
      S_CA1: state_d = S_CA2;
      S_CA2: state_d = S_LAT;
      S_LAT: begin
        if (cnt_q == LAT_LAST) state_d = S_DATA;
      end
      S_DATA: begin
        if (we_q) begin
          state_d = S_RECOV;
        end else if (rwds_i) begin
          state_d = S_RECOV;
          rd_hit  = 1'b1;
        end else if (cnt_q == TO_LAST) begin
          state_d = S_RECOV;
          rd_to   = 1'b1;
        end
      end
      S_RECOV: begin
        if (cnt_q == RECOV_LAST) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Counter restarts on every state entry and saturates instead of wrapping.
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Registered outputs decoded from the state being entered.
  always_comb begin
    ca        = {~we_d, 1'b0, 1'b1, adr_d[31:3], 13'd0, adr_d[2:0]};
    csn_d     = 1'b1;
    ck_en_d   = 1'b0;
    ddr_oe_d  = 1'b0;
    ddr_dat_d = 16'd0;
    rwds_oe_d = 1'b0;
    rwds_d    = 1'b0;
    ack_d     = (state_q == S_DATA) && (state_d == S_RECOV);
    err_d     = rd_to;
    busy_d    = (state_d != S_IDLE);
    dat_d     = rd_hit ? {ddr_dat_i[7:0], ddr_dat_i[15:8]} : dat_q;
    case (state_d)
      S_CA0: begin
        csn_d = 1'b0; ck_en_d = 1'b1; ddr_oe_d = 1'b1;
        ddr_dat_d = {ca[39:32], ca[47:40]};
      end
      S_CA1: begin
        csn_d = 1'b0; ck_en_d = 1'b1; ddr_oe_d = 1'b1;
        ddr_dat_d = {ca[23:16], ca[31:24]};
      end
      S_CA2: begin
        csn_d = 1'b0; ck_en_d = 1'b1; ddr_oe_d = 1'b1;
        ddr_dat_d = {ca[7:0], ca[15:8]};
      end
      S_LAT: begin
        csn_d = 1'b0; ck_en_d = 1'b1;
      end
      S_DATA: begin
        csn_d = 1'b0; ck_en_d = 1'b1;
        if (we_d) begin
          ddr_oe_d  = 1'b1;
          ddr_dat_d = {wdat_d[7:0], wdat_d[15:8]};
          rwds_oe_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Control state and output flops; reset may abort a transaction at any point.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      csn_q     <= 1'b1;
      ck_en_q   <= 1'b0;
      ddr_oe_q  <= 1'b0;
      ddr_dat_q <= 16'd0;
      rwds_oe_q <= 1'b0;
      rwds_q    <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      dat_q     <= 16'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      csn_q     <= csn_d;
      ck_en_q   <= ck_en_d;
      ddr_oe_q  <= ddr_oe_d;
      ddr_dat_q <= ddr_dat_d;
      rwds_oe_q <= rwds_oe_d;
      rwds_q    <= rwds_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      dat_q     <= dat_d;
    end
  end

  // Captured request fields; only consumed after a capture, so no reset needed.
  always_ff @(posedge clk_i) begin
    we_q   <= we_d;
    adr_q  <= adr_d;
    wdat_q <= wdat_d;
  end

  assign dat_o     = dat_q;
  assign ack_o     = ack_q;
  assign err_o     = err_q;
  assign busy_o    = busy_q;
  assign csn_o     = csn_q;
  assign ck_en_o   = ck_en_q;
  assign ddr_oe_o  = ddr_oe_q;
  assign ddr_dat_o = ddr_dat_q;
  assign rwds_oe_o = rwds_oe_q;
  assign rwds_o    = rwds_q;

endmodule

// File: tb/tb_hyperbus_xfer_ctrl.sv
// Bench for hyperbus_xfer_ctrl: transaction-level timeline model plus
// directed literal checks, followed by a randomized request stream.
module tb_hyperbus_xfer_ctrl;

  localparam int LATENCY  = 6;
  localparam int RECOVERY = 2;
  localparam int TIMEOUT  = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we  = 1'b0;
  logic [31:0] adr = 32'd0;
  logic [15:0] dat = 16'd0;
  logic [15:0] dat_o;
  logic        ack_o, err_o, busy_o, csn_o, ck_en_o, ddr_oe_o;
  logic [15:0] ddr_dat_o;
  logic [15:0] ddr_in = 16'd0;
  logic        rwds_oe_o, rwds_o;
  logic        rwds_in = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  // Read plan for the next accepted request: DATA cycle index where rwds
  // rises (-1 = never, so the read times out) and the word presented then.
  int          plan_d = -1;
  logic [15:0] plan_w = 16'd0;

  always #5 clk = ~clk;

  hyperbus_xfer_ctrl #(
    .ADDR_WIDTH(32), .LATENCY(LATENCY), .RECOVERY(RECOVERY), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .adr_i(adr), .dat_i(dat),
    .dat_o(dat_o), .ack_o(ack_o), .err_o(err_o), .busy_o(busy_o),
    .csn_o(csn_o), .ck_en_o(ck_en_o), .ddr_oe_o(ddr_oe_o), .ddr_dat_o(ddr_dat_o),
    .ddr_dat_i(ddr_in), .rwds_oe_o(rwds_oe_o), .rwds_o(rwds_o), .rwds_i(rwds_in)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic        csn, ck_en, oe, rwds_oe, ack, err, busy;
    logic [15:0] ddat;
    logic        upd;
    logic [15:0] new_dat;
    logic        rd_data, hit;
    logic [15:0] rd_word;
  } exp_t;

  exp_t        q[$];
  exp_t        cur;
  logic [15:0] dat_exp = 16'd0;

  function automatic exp_t idle_e();
    exp_t e = '0;
    e.csn = 1'b1;
    return e;
  endfunction

  function automatic exp_t active_e();
    exp_t e = '0;
    e.ck_en = 1'b1;
    e.busy  = 1'b1;
    return e;
  endfunction

  // Expand one accepted request into the full per-cycle output timeline.
  function automatic void build(input logic w, input logic [31:0] a, input logic [15:0] d,
                                input int rd_d, input logic [15:0] rw);
    logic [47:0] cw;
    exp_t        e;
    int          n;
    cw = {~w, 1'b0, 1'b1, a[31:3], 13'd0, a[2:0]};
    for (int i = 0; i < 3; i++) begin
      e = active_e();
      e.oe = 1'b1;
      e.ddat = (i == 0) ? {cw[39:32], cw[47:40]} :
               (i == 1) ? {cw[23:16], cw[31:24]} : {cw[7:0], cw[15:8]};
      q.push_back(e);
    end
    for (int i = 0; i < LATENCY; i++) q.push_back(active_e());
    if (w) begin
      e = active_e();
      e.oe = 1'b1; e.rwds_oe = 1'b1; e.ddat = {d[7:0], d[15:8]};
      q.push_back(e);
    end else begin
      n = (rd_d < 0) ? TIMEOUT : rd_d + 1;
      for (int i = 0; i < n; i++) begin
        e = active_e();
        e.rd_data = 1'b1; e.hit = (i == rd_d); e.rd_word = rw;
        q.push_back(e);
      end
    end
    for (int i = 0; i < RECOVERY; i++) begin
      e = idle_e();
      e.busy = 1'b1;
      if (i == 0) begin
        e.ack = 1'b1;
        e.err = !w && (rd_d < 0);
        e.upd = !w && (rd_d >= 0);
        e.new_dat = {rw[7:0], rw[15:8]};
      end
      q.push_back(e);
    end
    q.push_back(idle_e());
  endfunction

  initial cur = idle_e();

  // Advance the model at each edge and compare the DUT just after it.
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      cur = idle_e();
      dat_exp = 16'd0;
    end else if (q.size() != 0) begin
      cur = q.pop_front();
    end else if (req) begin
      build(we, adr, dat, plan_d, plan_w);
      cur = q.pop_front();
    end else begin
      cur = idle_e();
    end
    if (cur.upd) dat_exp = cur.new_dat;
    #1;
    chk("ctrl{csn,ck,oe,rwds_oe,ack,err,busy}",
        {25'd0, csn_o, ck_en_o, ddr_oe_o, rwds_oe_o, ack_o, err_o, busy_o},
        {25'd0, cur.csn, cur.ck_en, cur.oe, cur.rwds_oe, cur.ack, cur.err, cur.busy});
    if (cur.oe) chk("ddr_dat_o", 32'(ddr_dat_o), 32'(cur.ddat));
    if (cur.rwds_oe) chk("rwds_o", 32'(rwds_o), 32'd0);
    chk("dat_o", 32'(dat_o), 32'(dat_exp));
  end

  // PHY read side: rwds only at the planned DATA cycle, noise everywhere else.
  always @(negedge clk) begin
    if (cur.rd_data) begin
      rwds_in = cur.hit;
      ddr_in  = cur.hit ? cur.rd_word : 16'($urandom);
    end else begin
      rwds_in = 1'($urandom_range(0, 1));
      ddr_in  = 16'($urandom);
    end
  end

  // ---------------- directed + random stimulus ----------------
  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic wait_ack(output int cyc);
    cyc = 1;
    while (!ack_o && cyc < 200) begin
      nxt();
      cyc++;
    end
    chk("ack_seen", 32'(ack_o), 32'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && busy_o; i++) nxt();
    chk("idle_reached", 32'(busy_o), 32'd0);
  endtask

  int cyc, acks, hi;

  initial begin
    repeat (3) nxt();
    chk("rst_csn", 32'(csn_o), 32'd1);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_dat_o", 32'(dat_o), 32'd0);
    rst = 1'b0;
    nxt();

    // Write 0x1234 <- 0xBEEF
    req = 1'b1; we = 1'b1; adr = 32'h1234; dat = 16'hBEEF;
    nxt(); req = 1'b0;
    chk("t1_ca0", 32'(ddr_dat_o), 32'h0020);
    nxt(); chk("t1_ca1", 32'(ddr_dat_o), 32'h4602);
    nxt(); chk("t1_ca2", 32'(ddr_dat_o), 32'h0400);
    repeat (LATENCY) nxt();
    nxt();
    chk("t1_data", 32'(ddr_dat_o), 32'hEFBE);
    chk("t1_rwds_oe", 32'(rwds_oe_o), 32'd1);
    nxt(); chk("t1_ack_t11", 32'({ack_o, csn_o}), 32'b11);
    nxt(); chk("t1_t12", 32'({ack_o, csn_o, busy_o}), 32'b011);
    nxt(); chk("t1_idle_t13", 32'(busy_o), 32'd0);

    // Read 0x8, rwds in DATA cycle 3
    req = 1'b1; we = 1'b0; adr = 32'h8; plan_d = 3; plan_w = 16'h3412;
    nxt(); req = 1'b0;
    chk("t2_ca0", 32'(ddr_dat_o), 32'h00A0);
    wait_ack(cyc);
    chk("t2_ack_cycle", 32'(cyc), 32'(4 + LATENCY + 3 + 1));
    chk("t2_dat_o", 32'(dat_o), 32'h1234);
    chk("t2_err", 32'(err_o), 32'd0);
    wait_idle();

    // Read timeout
    req = 1'b1; we = 1'b0; adr = 32'h0000_0F00; plan_d = -1;
    nxt(); req = 1'b0;
    wait_ack(cyc);
    chk("t3_ack_cycle", 32'(cyc), 32'(4 + LATENCY + TIMEOUT));
    chk("t3_err", 32'(err_o), 32'd1);
    chk("t3_dat_o_held", 32'(dat_o), 32'h1234);
    wait_idle();

    // Reset in LAT cycle 3
    req = 1'b1; we = 1'b1; adr = 32'h55; dat = 16'h0102;
    nxt(); req = 1'b0;
    repeat (5) nxt();
    rst = 1'b1;
    nxt(); rst = 1'b0;
    chk("t4_csn", 32'(csn_o), 32'd1);
    chk("t4_busy", 32'(busy_o), 32'd0);
    acks = 0;
    repeat (20) begin nxt(); acks += int'(ack_o); end
    chk("t4_no_ack", 32'(acks), 32'd0);
    req = 1'b1; we = 1'b1; adr = 32'h77; dat = 16'hA5C3;
    nxt(); req = 1'b0;
    wait_ack(cyc);
    chk("t4_new_ack_cycle", 32'(cyc), 32'(5 + LATENCY));
    wait_idle();

    // Back-to-back with req held high
    req = 1'b1; we = 1'b1; adr = 32'h100; dat = 16'h1111;
    nxt();
    wait_ack(cyc);
    hi = 0;
    while (csn_o && hi < 50) begin hi++; nxt(); end
    chk("t5_csn_high_gap", 32'(hi), 32'(RECOVERY + 1));
    chk("t5_second_ca0", 32'({busy_o, csn_o}), 32'b10);
    req = 1'b0;
    wait_idle();

    // Random stream: req toggles freely, including while busy
    for (int i = 0; i < 3000; i++) begin
      req    = 1'($urandom_range(0, 1));
      we     = 1'($urandom_range(0, 1));
      adr    = $urandom;
      dat    = 16'($urandom);
      plan_w = 16'($urandom);
      if ($urandom_range(0, 4) == 0)       plan_d = -1;
      else if ($urandom_range(0, 3) == 0)  plan_d = $urandom_range(0, TIMEOUT - 1);
      else                                 plan_d = $urandom_range(0, 4);
      rst    = ($urandom_range(0, 299) == 0);
      nxt();
    end
    rst = 1'b0; req = 1'b0;
    wait_idle();
    repeat (3) nxt();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
